// File: rtl/mux_n_reg.sv
// N-channel valid/ready multiplexer with a registered output stage.
// Channel choice is either an external select or round-robin arbitration among valid inputs.
module mux_n_reg #(
  parameter int WIDTH   = 8,
  parameter int N       = 4,
  parameter int RR_MODE = 0,
  localparam int SELW   = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_src
);

  logic [WIDTH-1:0] outData_q, outData_d;
  logic             outValid_q, outValid_d;
  logic [SELW-1:0]  outSrc_q, outSrc_d;
  logic [SELW-1:0]  last_q, last_d;

  logic             loadEn;
  logic             candValid;
  logic [SELW-1:0]  cand;
  logic             candHasData;
  logic [WIDTH-1:0] candData;
  logic             grant;
  logic             transfer;
  int               rrIdx;

  assign loadEn = !outValid_q || out_ready;

  // Round-robin searches upward from the channel after the last grant, wrapping modulo N.
  always_comb begin
    candValid = 1'b0;
    cand      = '0;
    rrIdx     = 0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= N; k++) begin
        rrIdx = (int'(last_q) + k) % N;
        if (!candValid && in_valid[rrIdx]) begin
          candValid = 1'b1;
          cand      = SELW'(rrIdx);
        end
      end
    end else begin
      candValid = (int'(sel) < N);
      cand      = sel;
    end
  end

  always_comb begin
    candHasData = 1'b0;
    candData    = '0;
    for (int i = 0; i < N; i++) begin
      if (cand == SELW'(i)) begin
        candHasData = in_valid[i];
        candData    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Gating with rst_n keeps every channel stalled while the block is held in reset.
  assign grant    = rst_n && loadEn && candValid;
  assign transfer = grant && candHasData;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = grant && (cand == SELW'(i));
    end
  end

  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outSrc_d   = outSrc_q;
    last_d     = last_q;
    if (transfer) begin
      outValid_d = 1'b1;
      outData_d  = candData;
      outSrc_d   = cand;
      if (RR_MODE != 0) begin
        last_d = cand;
      end
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSrc_q   <= '0;
      last_q     <= SELW'(N - 1);
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outSrc_q   <= outSrc_d;
      last_q     <= last_d;
    end
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign out_src   = outSrc_q;

endmodule
